// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller that sequences a dp_ram with a 1-cycle read latency.
// Define SYNC_FIFO_ERR_EN to add the sticky ovf_err/udf_err outputs.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  rd_valid,
    output logic                  ram_w_enable,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic                  ram_r_enable,
    output logic [ADDR_WIDTH-1:0] ram_r_addr
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  ovf_err,
    output logic                  udf_err
`endif
);

    localparam logic [ADDR_WIDTH:0]   DEPTH   = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    // DATA_WIDTH only documents the attached dp_ram; reject a meaningless value early.
    if (DATA_WIDTH == 0) begin : g_bad_data_width
        $error("sync_fifo_ctrl: DATA_WIDTH must be nonzero");
    end

    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_nxt;

    assign wr_acc       = wr_req & ~full;
    assign rd_acc       = rd_req & ~empty;
    assign ram_w_enable = wr_acc;
    assign ram_r_enable = rd_acc;
    assign ram_w_addr   = wr_ptr;
    assign ram_r_addr   = rd_ptr;

    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Flags are registered from count_nxt so they never lag the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            count    <= count_nxt;
            full     <= (count_nxt == DEPTH);
            empty    <= (count_nxt == '0);
            rd_valid <= rd_acc;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_req & full)  ovf_err <= 1'b1;
            if (rd_req & empty) udf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a dp_ram stand-in plus a queue-based FIFO reference model.
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req;
    logic       rd_req;
    logic       full;
    logic       empty;
    logic [9:0] count;
    logic       rd_valid;
    logic       ram_w_enable;
    logic [8:0] ram_w_addr;
    logic       ram_r_enable;
    logic [8:0] ram_r_addr;
`ifdef SYNC_FIFO_ERR_EN
    logic       ovf_err;
    logic       udf_err;
`endif

    logic [7:0] wdata;
    logic [7:0] r_data;
    logic [7:0] mem [DEPTH];

    // reference model state
    logic [7:0] model_q [$];
    int         mwp;
    int         mrp;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic       exp_ovf;
    logic       exp_udf;
    logic [19:0] exp_ram;
    logic [19:0] act_ram;

    int checks   = 0;
    int failures = 0;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .rd_valid     (rd_valid),
        .ram_w_enable (ram_w_enable),
        .ram_w_addr   (ram_w_addr),
        .ram_r_enable (ram_r_enable),
        .ram_r_addr   (ram_r_addr)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
`endif
    );

    always #5 clk = ~clk;

    // dp_ram stand-in: both ports on clk, registered read
    always @(posedge clk) begin
        if (ram_w_enable) mem[ram_w_addr] <= wdata;
        if (ram_r_enable) r_data <= mem[ram_r_addr];
    end

    task automatic model_reset();
        model_q.delete();
        mwp = 0; mrp = 0;
        exp_valid = 1'b0;
        exp_ovf = 1'b0; exp_udf = 1'b0;
    endtask

    // Called at a negedge; returns at the next negedge with the model advanced.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        logic wa, ra;
        wr_req = w; rd_req = r; wdata = d;
        #1;
        wa = w && (model_q.size() < DEPTH);
        ra = r && (model_q.size() > 0);
        exp_ram = {wa, ra, 9'(mwp), 9'(mrp)};
        act_ram = {ram_w_enable, ram_r_enable, ram_w_addr, ram_r_addr};
        @(posedge clk);
        if (w && model_q.size() == DEPTH) exp_ovf = 1'b1;
        if (r && model_q.size() == 0)     exp_udf = 1'b1;
        if (ra) begin
            exp_rdata = model_q.pop_front();
            mrp = (mrp + 1) % DEPTH;
        end
        if (wa) begin
            model_q.push_back(d);
            mwp = (mwp + 1) % DEPTH;
        end
        exp_valid = ra;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            checks++;
            if (act_ram !== exp_ram) begin
                failures++; $display("FAIL reset_ram_if: got %h exp %h", act_ram, exp_ram);
            end
        end
        checks++;
        if ({empty, full, count, rd_valid} !== {1'b1, 1'b0, 10'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got empty=%b full=%b count=%0d rd_valid=%b exp 1 0 0 0",
                     empty, full, count, rd_valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, vals[i]);
            checks++;
            if (act_ram !== exp_ram || ram_w_addr !== 9'(i + 1)) begin
                failures++; $display("FAIL basic_push%0d: got %h exp %h", i, act_ram, exp_ram);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (act_ram !== exp_ram) begin
                failures++; $display("FAIL basic_pop_if%0d: got %h exp %h", i, act_ram, exp_ram);
            end
            checks++;
            if (rd_valid !== 1'b1 || r_data !== vals[i]) begin
                failures++;
                $display("FAIL basic_rdata%0d: got v=%b d=%h exp v=1 d=%h", i, rd_valid, r_data, vals[i]);
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 10'd0) begin
            failures++; $display("FAIL basic_empty: got empty=%b count=%0d exp 1 0", empty, count);
        end
    endtask

    task automatic test_full();
        int bad = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom));
            if (act_ram !== exp_ram) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL fill_ram_if: got %0d bad cycles exp 0", bad);
        end
        checks++;
        if ({full, empty, count, ram_w_addr} !== {1'b1, 1'b0, 10'd512, 9'd0}) begin
            failures++;
            $display("FAIL fill_state: got full=%b empty=%b count=%0d waddr=%0d exp 1 0 512 0",
                     full, empty, count, ram_w_addr);
        end
        cycle(1'b1, 1'b0, 8'hEE);
        checks++;
        if (act_ram[19] !== 1'b0 || count !== 10'd512 || full !== 1'b1) begin
            failures++;
            $display("FAIL overflow_push: got wen=%b count=%0d full=%b exp 0 512 1", act_ram[19], count, full);
        end
`ifdef SYNC_FIFO_ERR_EN
        checks++;
        if (ovf_err !== 1'b1 || udf_err !== 1'b0) begin
            failures++; $display("FAIL ovf_err: got ovf=%b udf=%b exp 1 0", ovf_err, udf_err);
        end
`endif
    endtask

    task automatic test_simultaneous();
        int bad = 0;
        cycle(1'b1, 1'b1, 8'h5A);
        checks++;
        if (act_ram[19:18] !== 2'b01) begin
            failures++; $display("FAIL full_both_en: got wen/ren=%b exp 01", act_ram[19:18]);
        end
        checks++;
        if (count !== 10'd511 || full !== 1'b0 || rd_valid !== 1'b1 || r_data !== exp_rdata) begin
            failures++;
            $display("FAIL full_both_state: got count=%0d full=%b v=%b d=%h exp 511 0 1 %h",
                     count, full, rd_valid, r_data, exp_rdata);
        end
        for (int i = 0; i < 511; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            if (rd_valid !== 1'b1 || r_data !== exp_rdata) bad++;
        end
        checks++;
        if (bad != 0 || empty !== 1'b1) begin
            failures++; $display("FAIL drain_full: got %0d bad reads empty=%b exp 0 1", bad, empty);
        end
        cycle(1'b1, 1'b1, 8'hA5);
        checks++;
        if (act_ram[19:18] !== 2'b10) begin
            failures++; $display("FAIL empty_both_en: got wen/ren=%b exp 10", act_ram[19:18]);
        end
        checks++;
        if (count !== 10'd1 || rd_valid !== 1'b0 || empty !== 1'b0) begin
            failures++;
            $display("FAIL empty_both_state: got count=%0d v=%b empty=%b exp 1 0 0", count, rd_valid, empty);
        end
`ifdef SYNC_FIFO_ERR_EN
        checks++;
        if (udf_err !== exp_udf || ovf_err !== exp_ovf) begin
            failures++;
            $display("FAIL sticky_err: got ovf=%b udf=%b exp %b %b", ovf_err, udf_err, exp_ovf, exp_udf);
        end
`endif
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (rd_valid !== 1'b1 || r_data !== 8'hA5) begin
            failures++; $display("FAIL empty_both_data: got v=%b d=%h exp 1 a5", rd_valid, r_data);
        end
    endtask

    task automatic test_wrap();
        int bad = 0;
        int cbad = 0;
        for (int i = 0; i < 500; i++) cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 500; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            if (rd_valid !== 1'b1 || r_data !== exp_rdata) bad++;
            if (count !== 10'(model_q.size()) || act_ram !== exp_ram) cbad++;
        end
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'($urandom));
        checks++;
        if (count !== 10'd20 || ram_w_addr !== 9'(mwp)) begin
            failures++;
            $display("FAIL wrap_fill: got count=%0d waddr=%0d exp 20 %0d", count, ram_w_addr, mwp);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            if (rd_valid !== 1'b1 || r_data !== exp_rdata) bad++;
            if (count !== 10'(model_q.size()) || act_ram !== exp_ram) cbad++;
        end
        checks++;
        if (bad != 0 || cbad != 0) begin
            failures++; $display("FAIL wrap_order: got %0d data / %0d ctl errors exp 0 0", bad, cbad);
        end
    endtask

    task automatic test_random();
        int wp;
        int rp;
        for (int i = 0; i < 3000; i++) begin
            wp = ((i / 400) % 2 == 0) ? 75 : 30;
            rp = 100 - wp;
            cycle(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), 8'($urandom));
            checks++;
            if (act_ram !== exp_ram) begin
                failures++; $display("FAIL rand_ram_if @%0d: got %h exp %h", i, act_ram, exp_ram);
            end
            checks++;
            if (count !== 10'(model_q.size()) || full !== (model_q.size() == DEPTH)
                || empty !== (model_q.size() == 0)) begin
                failures++;
                $display("FAIL rand_count @%0d: got count=%0d full=%b empty=%b exp %0d",
                         i, count, full, empty, model_q.size());
            end
            checks++;
            if (rd_valid !== exp_valid || (exp_valid && r_data !== exp_rdata)) begin
                failures++;
                $display("FAIL rand_rdata @%0d: got v=%b d=%h exp v=%b d=%h",
                         i, rd_valid, r_data, exp_valid, exp_rdata);
            end
`ifdef SYNC_FIFO_ERR_EN
            checks++;
            if (ovf_err !== exp_ovf || udf_err !== exp_udf) begin
                failures++;
                $display("FAIL rand_err @%0d: got %b%b exp %b%b", i, ovf_err, udf_err, exp_ovf, exp_udf);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(i + 8'h40));
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1) begin
            failures++; $display("FAIL mid_pre_valid: got %b exp 1", rd_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({rd_valid, count, empty, full, ram_w_addr, ram_r_addr} !== {1'b0, 10'd0, 1'b1, 1'b0, 9'd0, 9'd0}) begin
            failures++;
            $display("FAIL mid_reset: got v=%b count=%0d empty=%b full=%b wa=%0d ra=%0d exp 0 0 1 0 0 0",
                     rd_valid, count, empty, full, ram_w_addr, ram_r_addr);
        end
`ifdef SYNC_FIFO_ERR_EN
        checks++;
        if (udf_err !== 1'b0 || ovf_err !== 1'b0) begin
            failures++; $display("FAIL mid_reset_err: got %b%b exp 00", ovf_err, udf_err);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 8'h77);
        checks++;
        if (act_ram !== exp_ram || count !== 10'd1) begin
            failures++; $display("FAIL post_reset_push: got %h cnt=%0d exp %h 1", act_ram, count, exp_ram);
        end
    endtask

    initial begin
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wdata = 8'h00;
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_simultaneous();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
